int_alu_rs: RTL
===============

Name: int_alu_rs

Overview:
Reservation station and issue scheduler for one integer ALU. It accepts renamed ALU micro-ops from dispatch and captures missing source operands from the CDB broadcast. Each cycle it selects the oldest entry with both operands ready and drives the registered ex1 issue bundle (alu_val_ex1, op1_ex1, op2_ex1, alu_ctrl_ex1, robid_ex1) into the ALU. It sits between rename/dispatch and the int ALU.

Parameters:
RS_DEPTH, 8, number of entries (power of 2, >=2)
CDB_PORTS, 2, number of result broadcast buses snooped for wakeup
DATA_LEN, 32, operand width (package constant)
ALU_CTRL_WIDTH, 4, ALU op encoding width (package constant)
ROB_SIZE_CLOG, 5, ROB id / tag width (package constant)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset; asynchronous, active-high
disp_val  in  1  dispatch uop valid
disp_rdy  out  1  station can accept (not full)
disp_alu_ctrl  in  ALU_CTRL_WIDTH  ALU op
disp_robid  in  ROB_SIZE_CLOG  destination ROB id
disp_src1_rdy, disp_src2_rdy  in  1 each  operand value already valid
disp_src1_data, disp_src2_data  in  DATA_LEN each  operand value (used if rdy)
disp_src1_tag, disp_src2_tag  in  ROB_SIZE_CLOG each  producer ROB id (used if !rdy)
cdb_val  in  CDB_PORTS  broadcast valid per port
cdb_robid  in  CDB_PORTS*ROB_SIZE_CLOG  broadcast producer id
cdb_data  in  CDB_PORTS*DATA_LEN  broadcast result
ex_rdy  in  1  ALU stage can accept a new op
flush  in  1  pipeline flush (mispredict/exception)
alu_val_ex1  out  1  issued op valid
op1_ex1, op2_ex1  out  DATA_LEN each  issued operands
alu_ctrl_ex1  out  ALU_CTRL_WIDTH  issued op
robid_ex1  out  ROB_SIZE_CLOG  issued ROB id
rs_occ  out  clog2(RS_DEPTH)+1  occupied entry count

Behaviour:
- Reset (async, rst=1): all entries invalid, age state cleared, alu_val_ex1=0, op1_ex1/op2_ex1/alu_ctrl_ex1/robid_ex1=0, rs_occ=0, disp_rdy=1 once rst deasserts.
- disp_rdy = (rs_occ != RS_DEPTH), combinational from current occupancy only. An issue in the same cycle does not free a slot for same-cycle dispatch.
- Allocation: when disp_val && disp_rdy, write the lowest-index free entry at the edge; the entry becomes youngest.
  - disp_val while !disp_rdy is ignored. Dispatch must hold the uop.
- Wakeup: for every valid entry with a not-ready source whose tag equals cdb_robid[p] with cdb_val[p]=1, capture cdb_data[p] and mark the source ready at the edge.
  - If several ports match, the lowest port index wins.
- Dispatch bypass: a dispatching source with rdy=0 whose tag matches an active CDB port in the same cycle is written as ready with that CDB data. A wakeup is never lost.
- Select: an entry is eligible when valid and both sources ready in the current state (no same-cycle CDB-to-issue bypass). Among eligible entries, the oldest by dispatch order wins. One issue per cycle.
- Issue: if ex_rdy=1 and an entry is eligible, the next edge loads the ex1 registers with its payload, sets alu_val_ex1=1 and invalidates the entry. Otherwise alu_val_ex1=0 at the next edge.
  - If ex_rdy=0, the ex1 registers hold their values (including valid) and no entry issues.
- Latency: CDB match at edge N makes the entry eligible in cycle N..N+1; the earliest alu_val_ex1 is at edge N+1. Dispatch-to-issue minimum is 1 edge for a fully ready uop in an empty station.
- Flush: has priority over dispatch, wakeup and issue. At the edge, all entries are invalidated, alu_val_ex1=0 and rs_occ=0; concurrent disp_val is dropped.
- rs_occ is updated every edge: +1 on allocation, -1 on issue, both may occur together. It never exceeds RS_DEPTH.
- Tags are compared only on not-ready sources; ready sources ignore CDB.

Decomposition:
- Shared package: DATA_LEN, ALU_CTRL_WIDTH, ROB_SIZE_CLOG, and a packed struct rs_entry_t {valid, alu_ctrl, robid, src1/src2 {rdy, tag, data}}.
- Sub-module rs_age_picker: RS_DEPTH x RS_DEPTH age matrix with set-on-allocate and clear-on-free/flush. It takes the eligible vector and returns a one-hot oldest grant plus a grant-valid flag.

Test Plan:
- Reset then dispatch ADD_OP robid=3, src1=5 rdy, src2=7 rdy, ex_rdy=1 -> next edge alu_val_ex1=1, op1_ex1=5, op2_ex1=7, robid_ex1=3, rs_occ back to 0.
- Dispatch robid=4 with src1 tag=9 not ready; two cycles later cdb_val[1]=1, cdb_robid=9, cdb_data=0x10 -> one edge later alu_val_ex1=1, op1_ex1=0x10.
- Dispatch robid=1, then robid=2 (both waiting on tag 6); broadcast tag 6 -> robid_ex1=1 issues first, then robid_ex1=2 on the following edge (oldest-first).
- Fill 8 entries all waiting -> disp_rdy=0, rs_occ=8. A 9th disp_val is ignored. One wakeup and issue -> disp_rdy=1 the cycle after.
- Dispatch src2 tag=12 while cdb_robid[0]=12, data=0xAB in the same cycle -> entry issues next edge with op2_ex1=0xAB.
- Four ready entries, flush asserted together with disp_val -> next edge alu_val_ex1=0, rs_occ=0, no later issue. Also assert rst mid-issue -> outputs zero immediately, asynchronously.

Source files
------------

// File: rtl/int_alu_rs_pkg.sv
// Shared types and widths for the integer ALU reservation station.
package int_alu_rs_pkg;

    localparam int DATA_LEN       = 32;
    localparam int ALU_CTRL_WIDTH = 4;
    localparam int ROB_SIZE_CLOG  = 5;

    typedef enum logic [ALU_CTRL_WIDTH-1:0] {
        ADD_OP  = 4'd0,
        SUB_OP  = 4'd1,
        AND_OP  = 4'd2,
        OR_OP   = 4'd3,
        XOR_OP  = 4'd4,
        SLL_OP  = 4'd5,
        SRL_OP  = 4'd6,
        SRA_OP  = 4'd7,
        SLT_OP  = 4'd8,
        SLTU_OP = 4'd9
    } alu_op_e;

    // One source operand: either a captured value (rdy=1) or the producer tag it waits on.
    typedef struct packed {
        logic                     rdy;
        logic [ROB_SIZE_CLOG-1:0] tag;
        logic [DATA_LEN-1:0]      data;
    } rs_src_t;

    typedef struct packed {
        logic                      valid;
        logic [ALU_CTRL_WIDTH-1:0] alu_ctrl;
        logic [ROB_SIZE_CLOG-1:0]  robid;
        rs_src_t                   src1;
        rs_src_t                   src2;
    } rs_entry_t;

endpackage

// File: rtl/int_alu_rs_age_picker.sv
// Age matrix for the reservation station: age_q[i][j]=1 means entry i is older than j.
// Grants the single eligible entry that no other eligible entry is older than.
module rs_age_picker
    import int_alu_rs_pkg::*;
#(
    parameter int RS_DEPTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush_i,
    input  logic [RS_DEPTH-1:0] alloc_oh_i,
    input  logic [RS_DEPTH-1:0] free_oh_i,
    input  logic [RS_DEPTH-1:0] eligible_i,
    output logic [RS_DEPTH-1:0] grant_o,
    output logic                grant_val_o
);

    logic [RS_DEPTH-1:0] age_q [RS_DEPTH];
    logic [RS_DEPTH-1:0] age_d [RS_DEPTH];
    logic [RS_DEPTH-1:0] blocked;

    // A new entry is younger than everyone: clear its row, set its column.
    always_comb begin
        for (int i = 0; i < RS_DEPTH; i++) begin
            for (int j = 0; j < RS_DEPTH; j++) begin
                age_d[i][j] = age_q[i][j];
                if (i == j || flush_i) begin
                    age_d[i][j] = 1'b0;
                end else if (alloc_oh_i[i]) begin
                    age_d[i][j] = 1'b0;
                end else if (alloc_oh_i[j]) begin
                    age_d[i][j] = 1'b1;
                end else if (free_oh_i[i] || free_oh_i[j]) begin
                    age_d[i][j] = 1'b0;
                end
            end
        end
    end

    // Age matrix register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                age_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                age_q[i] <= age_d[i];
            end
        end
    end

    // An eligible entry is blocked if any other eligible entry is older than it.
    always_comb begin
        blocked = '0;
        grant_o = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            for (int j = 0; j < RS_DEPTH; j++) begin
                if (eligible_i[j] && age_q[j][i]) begin
                    blocked[i] = 1'b1;
                end
            end
            grant_o[i] = eligible_i[i] && !blocked[i];
        end
    end

    assign grant_val_o = |eligible_i;

endmodule

// File: rtl/int_alu_rs.sv
// Reservation station and oldest-first issue scheduler for one integer ALU.
module int_alu_rs
    import int_alu_rs_pkg::*;
#(
    parameter int RS_DEPTH  = 8,
    parameter int CDB_PORTS = 2
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               disp_val,
    output logic                               disp_rdy,
    input  logic [ALU_CTRL_WIDTH-1:0]          disp_alu_ctrl,
    input  logic [ROB_SIZE_CLOG-1:0]           disp_robid,
    input  logic                               disp_src1_rdy,
    input  logic                               disp_src2_rdy,
    input  logic [DATA_LEN-1:0]                disp_src1_data,
    input  logic [DATA_LEN-1:0]                disp_src2_data,
    input  logic [ROB_SIZE_CLOG-1:0]           disp_src1_tag,
    input  logic [ROB_SIZE_CLOG-1:0]           disp_src2_tag,
    input  logic [CDB_PORTS-1:0]               cdb_val,
    input  logic [CDB_PORTS*ROB_SIZE_CLOG-1:0] cdb_robid,
    input  logic [CDB_PORTS*DATA_LEN-1:0]      cdb_data,
    input  logic                               ex_rdy,
    input  logic                               flush,
    output logic                               alu_val_ex1,
    output logic [DATA_LEN-1:0]                op1_ex1,
    output logic [DATA_LEN-1:0]                op2_ex1,
    output logic [ALU_CTRL_WIDTH-1:0]          alu_ctrl_ex1,
    output logic [ROB_SIZE_CLOG-1:0]           robid_ex1,
    output logic [$clog2(RS_DEPTH):0]          rs_occ
);

    localparam int OCC_W = $clog2(RS_DEPTH) + 1;

    rs_entry_t entries_q [RS_DEPTH];
    rs_entry_t entries_d [RS_DEPTH];
    rs_entry_t newEntry;

    logic [OCC_W-1:0]          occ_q, occ_d;
    logic [RS_DEPTH-1:0]       eligibleVec, allocOh, allocGated, freeOh, grantOh;
    logic                      grantVal, doAlloc, doIssue;
    logic [ALU_CTRL_WIDTH-1:0] pickCtrl;
    logic [ROB_SIZE_CLOG-1:0]  pickRobid;
    logic [DATA_LEN-1:0]       pickOp1, pickOp2;

    logic                      aluVal_q, aluVal_d;
    logic [DATA_LEN-1:0]       op1_q, op1_d, op2_q, op2_d;
    logic [ALU_CTRL_WIDTH-1:0] aluCtrl_q, aluCtrl_d;
    logic [ROB_SIZE_CLOG-1:0]  robid_q, robid_d;

    // Snoop the CDB for a waiting source; iterating high-to-low lets the lowest port win.
    function automatic rs_src_t wakeSrc(input rs_src_t s,
                                        input logic [CDB_PORTS-1:0] v,
                                        input logic [CDB_PORTS*ROB_SIZE_CLOG-1:0] ids,
                                        input logic [CDB_PORTS*DATA_LEN-1:0] d);
        wakeSrc = s;
        if (!s.rdy) begin
            for (int p = CDB_PORTS - 1; p >= 0; p--) begin
                if (v[p] && ids[p*ROB_SIZE_CLOG +: ROB_SIZE_CLOG] == s.tag) begin
                    wakeSrc.rdy  = 1'b1;
                    wakeSrc.data = d[p*DATA_LEN +: DATA_LEN];
                end
            end
        end
    endfunction

    assign disp_rdy   = (occ_q != OCC_W'(RS_DEPTH));
    assign doAlloc    = disp_val && disp_rdy && !flush;
    assign doIssue    = ex_rdy && grantVal && !flush;
    assign allocGated = doAlloc ? allocOh : '0;
    assign freeOh     = doIssue ? grantOh : '0;

    // Lowest-index free slot and per-entry eligibility from the current state only.
    always_comb begin
        allocOh     = '0;
        eligibleVec = '0;
        for (int i = RS_DEPTH - 1; i >= 0; i--) begin
            if (!entries_q[i].valid) begin
                allocOh    = '0;
                allocOh[i] = 1'b1;
            end
            eligibleVec[i] = entries_q[i].valid && entries_q[i].src1.rdy && entries_q[i].src2.rdy;
        end
    end

    rs_age_picker #(.RS_DEPTH(RS_DEPTH)) u_age_picker (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (flush),
        .alloc_oh_i  (allocGated),
        .free_oh_i   (freeOh),
        .eligible_i  (eligibleVec),
        .grant_o     (grantOh),
        .grant_val_o (grantVal)
    );

    // Build the incoming entry, letting same-cycle CDB results fill its waiting sources.
    always_comb begin
        newEntry          = '0;
        newEntry.valid    = 1'b1;
        newEntry.alu_ctrl = disp_alu_ctrl;
        newEntry.robid    = disp_robid;
        newEntry.src1     = wakeSrc({disp_src1_rdy, disp_src1_tag, disp_src1_data}, cdb_val, cdb_robid, cdb_data);
        newEntry.src2     = wakeSrc({disp_src2_rdy, disp_src2_tag, disp_src2_data}, cdb_val, cdb_robid, cdb_data);
    end

    // Entry update: wakeup, then free on issue, then allocation; flush overrides everything.
    always_comb begin
        for (int i = 0; i < RS_DEPTH; i++) begin
            entries_d[i] = entries_q[i];
            if (entries_q[i].valid) begin
                entries_d[i].src1 = wakeSrc(entries_q[i].src1, cdb_val, cdb_robid, cdb_data);
                entries_d[i].src2 = wakeSrc(entries_q[i].src2, cdb_val, cdb_robid, cdb_data);
            end
            if (freeOh[i]) begin
                entries_d[i].valid = 1'b0;
            end
            if (doAlloc && allocOh[i]) begin
                entries_d[i] = newEntry;
            end
            if (flush) begin
                entries_d[i].valid = 1'b0;
            end
        end
    end

    // Mux out the payload of the granted entry.
    always_comb begin
        pickCtrl  = '0;
        pickRobid = '0;
        pickOp1   = '0;
        pickOp2   = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            if (grantOh[i]) begin
                pickCtrl  = entries_q[i].alu_ctrl;
                pickRobid = entries_q[i].robid;
                pickOp1   = entries_q[i].src1.data;
                pickOp2   = entries_q[i].src2.data;
            end
        end
    end

    // ex1 bundle: hold while the ALU stalls, otherwise load the winner or go idle.
    always_comb begin
        aluVal_d  = aluVal_q;
        op1_d     = op1_q;
        op2_d     = op2_q;
        aluCtrl_d = aluCtrl_q;
        robid_d   = robid_q;
        occ_d     = occ_q + OCC_W'(doAlloc) - OCC_W'(doIssue);
        if (flush) begin
            aluVal_d = 1'b0;
            occ_d    = '0;
        end else if (ex_rdy) begin
            aluVal_d = grantVal;
            if (grantVal) begin
                op1_d     = pickOp1;
                op2_d     = pickOp2;
                aluCtrl_d = pickCtrl;
                robid_d   = pickRobid;
            end
        end
    end

    // State registers for entries, occupancy and the ex1 bundle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                entries_q[i] <= '0;
            end
            occ_q     <= '0;
            aluVal_q  <= 1'b0;
            op1_q     <= '0;
            op2_q     <= '0;
            aluCtrl_q <= '0;
            robid_q   <= '0;
        end else begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                entries_q[i] <= entries_d[i];
            end
            occ_q     <= occ_d;
            aluVal_q  <= aluVal_d;
            op1_q     <= op1_d;
            op2_q     <= op2_d;
            aluCtrl_q <= aluCtrl_d;
            robid_q   <= robid_d;
        end
    end

    assign rs_occ       = occ_q;
    assign alu_val_ex1  = aluVal_q;
    assign op1_ex1      = op1_q;
    assign op2_ex1      = op2_q;
    assign alu_ctrl_ex1 = aluCtrl_q;
    assign robid_ex1    = robid_q;

endmodule
